elevator_request_scheduler: RTL
===============================

Name: elevator_request_scheduler

Overview:
Upstream stage of the elevator controller. Latches hall/car floor requests into a pending bitmap and picks the next destination using LOOK ordering: keep serving in the current direction, reverse only when nothing is left ahead. Drives `dest_floor` into the controller and waits on its `finish`. Then holds the door open for a fixed dwell before picking the next target.

Parameters:
- NUM_FLOORS, 6, number of served floors (floors 0..NUM_FLOORS-1)
- FLOOR_W, 3, width of floor indices; must satisfy 2^FLOOR_W >= NUM_FLOORS
- DOOR_CYCLES, 20, cycles `door_open` stays high per stop (>=1)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  single-cycle request strobe
- req_floor  in  FLOOR_W  requested floor, sampled when req_valid=1
- finish  in  1  from controller; 1 when controller floor == dest_floor (combinational there)
- dest_floor  out  FLOOR_W  registered destination to controller
- door_open  out  1  door held open at cur_floor
- busy  out  1  state != IDLE
- dir_up  out  1  current LOOK direction (1=up)
- pending  out  NUM_FLOORS  outstanding request bitmap

Behaviour:
- One clock, synchronous active-high reset.
- Reset values:
  - state=IDLE, dest_floor=0, cur_floor=0, pending=0
  - door_open=0, dir_up=1, dwell counter=0, busy=0
- Request capture:
  - req_valid with req_floor<NUM_FLOORS sets pending[req_floor] at the next edge.
  - req_floor>=NUM_FLOORS is ignored.
  - Duplicate requests are idempotent.
- States: IDLE, SELECT, TRAVEL, DOOR.
- IDLE:
  - pending!=0 -> SELECT.
  - Otherwise stay; dest_floor holds cur_floor.
- SELECT (one cycle): choose a target from pending.
  - dir_up=1: nearest set bit > cur_floor. If none, nearest set bit < cur_floor and dir_up<=0.
  - dir_up=0: symmetric (nearest below first, else nearest above and dir_up<=1).
  - If only pending[cur_floor] is set: target=cur_floor and dir_up is unchanged.
  - Register dest_floor<=target.
  - Next state: target==cur_floor -> DOOR; otherwise -> TRAVEL.
- TRAVEL:
  - dest_floor is frozen; new requests only set pending bits (no retarget mid-travel).
  - Because dest_floor is registered before TRAVEL, finish is valid from the first TRAVEL cycle.
  - On finish=1: cur_floor<=dest_floor and go to DOOR.
- DOOR entry (from SELECT or TRAVEL):
  - Clear pending[cur_floor]; a same-cycle request for that floor is absorbed, so clear wins.
  - Load the dwell counter with DOOR_CYCLES.
  - door_open=1 exactly DOOR_CYCLES cycles.
- While in DOOR:
  - A new req_floor==cur_floor does not set pending; it reloads the dwell counter (door re-open).
  - Other floors set pending normally.
  - Counter expiry: door_open<=0; pending!=0 -> SELECT, else IDLE.
- door_open is registered; it rises on the edge that enters DOOR.
- Latency from an idle req_valid on cycle N:
  - pending visible at N+1
  - SELECT at N+2
  - dest_floor updated at N+3
- finish=0 is ignored outside TRAVEL; finish outside TRAVEL has no effect.
- Reset mid-operation:
  - All state is returned to reset values and pending requests are dropped.
  - dest_floor returns to 0, which the controller also resets to.
- Wrap-around: none. Direction reversal occurs only at the extreme of pending requests.

Test Plan:
- Reset, req floor 3, controller model (11 cycles/floor) -> dest_floor=3 by cycle N+3, finish after 33 cycles, door_open high 20 cycles, pending=0, busy drops.
- At floor 0, requests {4,2} same burst -> service order 2 then 4, dir_up stays 1, two DOOR windows.
- At floor 3 going up, pending {1,5} -> 5 first, then dir_up=0, then 1.
- Idle at floor 2, req floor 2 -> no TRAVEL, DOOR after SELECT, dest_floor stays 2, door 20 cycles; repeat req during DOOR -> dwell restarts.
- req_floor=7 with NUM_FLOORS=6 -> pending unchanged, busy stays 0; req during TRAVEL for floor 1 while going 0->4 -> dest_floor stays 4 until finish.
- rst asserted mid-TRAVEL with pending {3,5} -> next cycle pending=0, dest_floor=0, door_open=0, state IDLE.

Source files
------------

// File: rtl/elevator_request_scheduler.sv
// elevator_request_scheduler: LOOK-ordered destination picker with door dwell timing
module elevator_request_scheduler #(
  parameter int NUM_FLOORS  = 6,
  parameter int FLOOR_W     = 3,
  parameter int DOOR_CYCLES = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic [FLOOR_W-1:0]    req_floor,
  input  logic                  finish,
  output logic [FLOOR_W-1:0]    dest_floor,
  output logic                  door_open,
  output logic                  busy,
  output logic                  dir_up,
  output logic [NUM_FLOORS-1:0] pending
);
  localparam int CW = $clog2(DOOR_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, SELECT, TRAVEL, DOOR} state_t;
  state_t state;
  logic [FLOOR_W-1:0] cur_floor, up_t, dn_t, target;
  logic found_up, found_dn, nxt_dir, req_ok, door_entry;
  logic [NUM_FLOORS-1:0] set_m, clr_m, pending_nxt;
  logic [CW-1:0] cnt;
  // nearest pending floor above (lowest such) and below (highest such) the car
  always_comb begin
    found_up = 1'b0;
    up_t = '0;
    found_dn = 1'b0;
    dn_t = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--)
      if (pending[i] && FLOOR_W'(i) > cur_floor) begin
        found_up = 1'b1;
        up_t = FLOOR_W'(i);
      end
    for (int i = 0; i < NUM_FLOORS; i++)
      if (pending[i] && FLOOR_W'(i) < cur_floor) begin
        found_dn = 1'b1;
        dn_t = FLOOR_W'(i);
      end
  end
  assign target = dir_up ? (found_up ? up_t : found_dn ? dn_t : cur_floor)
                         : (found_dn ? dn_t : found_up ? up_t : cur_floor);
  assign nxt_dir = dir_up ? (found_up || !found_dn) : (!found_dn && found_up);
  assign req_ok = req_valid && ({1'b0, req_floor} < (FLOOR_W + 1)'(NUM_FLOORS));
  assign set_m = req_ok ? NUM_FLOORS'(1) << req_floor : '0;
  assign door_entry = (state == SELECT && target == cur_floor) || (state == TRAVEL && finish);
  // the floor being served is masked on door entry and for the whole dwell, so a
  // request for it never lands in pending
  assign clr_m = (door_entry || state == DOOR)
               ? NUM_FLOORS'(1) << (state == TRAVEL ? dest_floor : cur_floor) : '0;
  assign pending_nxt = (pending | set_m) & ~clr_m;
  assign busy = state != IDLE;
  // scheduler state machine with registered destination, direction and door outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      dest_floor <= '0;
      cur_floor <= '0;
      pending <= '0;
      door_open <= 1'b0;
      dir_up <= 1'b1;
      cnt <= '0;
    end else begin
      pending <= pending_nxt;
      case (state)
        IDLE: begin
          dest_floor <= cur_floor;
          if (|pending) state <= SELECT;
        end
        SELECT: begin
          dest_floor <= target;
          dir_up <= nxt_dir;
          if (target == cur_floor) begin
            state <= DOOR;
            door_open <= 1'b1;
            cnt <= CW'(DOOR_CYCLES);
          end else state <= TRAVEL;
        end
        TRAVEL: if (finish) begin
          cur_floor <= dest_floor;
          state <= DOOR;
          door_open <= 1'b1;
          cnt <= CW'(DOOR_CYCLES);
        end
        DOOR: begin
          if (req_ok && req_floor == cur_floor) cnt <= CW'(DOOR_CYCLES);
          else if (cnt == CW'(1)) begin
            door_open <= 1'b0;
            state <= |pending_nxt ? SELECT : IDLE;
          end else cnt <= cnt - 1'b1;
        end
      endcase
    end
  end
endmodule
